// File: rtl/crc_sort_pkg.sv
// Shared constants and state encoding for the crc_sort scheduler slice.
package crc_sort_pkg;

  localparam logic [2:0] FN_CRC_GEN = 3'b011;
  localparam logic [2:0] FN_SORT    = 3'b100;
  localparam int         CRC_LAT    = 130;
  localparam int         SORT_LAT   = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  function automatic logic fn_is_legal(input logic [2:0] fn);
    return (fn == FN_CRC_GEN) || (fn == FN_SORT);
  endfunction

endpackage

// File: rtl/crc_sort_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, searching cyclically.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     grant_idx_o,
  output logic               any_o
);

  localparam int SW = IDW + 1;

  logic [SW-1:0]  sum;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    sum         = '0;
    idx         = '0;
    found       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit holds ptr+k before the wrap back into 0..NUM_REQ-1.
      sum = {1'b0, ptr_i} + SW'(k);
      if (sum >= SW'(NUM_REQ)) begin
        sum = sum - SW'(NUM_REQ);
      end
      idx = sum[IDW-1:0];
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/crc_sort_sched.sv
// Round-robin job scheduler in front of one shared crc_sort_core.
// Optional watchdog in WAIT is built when CRC_SORT_SCHED_TIMEOUT_EN is defined.
module crc_sort_sched
  import crc_sort_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [3*NUM_REQ-1:0]   req_fn_sel,
  input  logic [128*NUM_REQ-1:0] req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   core_start,
  output logic [2:0]             core_fn_sel,
  output logic [127:0]           core_data_in,
  input  logic [127:0]           core_data_out,
  input  logic                   core_done
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC <= 130 || TIMEOUT_CYC > 256) begin : g_bad_params
    $error("crc_sort_sched: NUM_REQ must be 2..8 and TIMEOUT_CYC 131..256");
  end

  logic [2:0]   fn_a   [NUM_REQ];
  logic [127:0] data_a [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign fn_a[gi]   = req_fn_sel[3*gi +: 3];
    assign data_a[gi] = req_data[128*gi +: 128];
  end

  sched_state_e   state_q;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] job_id_q;
  logic           core_start_q;
  logic [2:0]     core_fn_q;
  logic [127:0]   core_data_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [127:0]   rsp_data_q;
  logic           rsp_err_q;

`ifdef CRC_SORT_SCHED_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wdog_q;
`endif

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               any_req;
  logic [2:0]         grant_fn;
  logic [127:0]       grant_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (any_req)
  );

  assign grant_fn   = fn_a[grant_idx];
  assign grant_data = data_a[grant_idx];

  always_comb begin
    rr_ptr_d = grant_idx + 1'b1;
    if (grant_idx == IDW'(NUM_REQ - 1)) begin
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      job_id_q     <= '0;
      core_start_q <= 1'b0;
      core_fn_q    <= '0;
      core_data_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
`ifdef CRC_SORT_SCHED_TIMEOUT_EN
      wdog_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            rr_ptr_q <= rr_ptr_d;
            job_id_q <= grant_idx;
            // Core-facing fields only move for legal jobs, keeping the core's done mux steady.
            if (fn_is_legal(grant_fn)) begin
              core_fn_q    <= grant_fn;
              core_data_q  <= grant_data;
              core_start_q <= 1'b1;
              state_q      <= ST_ISSUE;
            end else begin
              rsp_id_q    <= grant_idx;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          core_start_q <= 1'b0;
          state_q      <= ST_WAIT;
`ifdef CRC_SORT_SCHED_TIMEOUT_EN
          wdog_q       <= '0;
`endif
        end
        ST_WAIT: begin
          if (core_done) begin
            rsp_id_q    <= job_id_q;
            rsp_data_q  <= core_data_out;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
`ifdef CRC_SORT_SCHED_TIMEOUT_EN
          else if (wdog_q == WDOG_LAST) begin
            rsp_id_q    <= job_id_q;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == ST_IDLE) ? grant : '0;
  assign busy         = (state_q != ST_IDLE);
  assign core_start   = core_start_q;
  assign core_fn_sel  = core_fn_q;
  assign core_data_in = core_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_crc_sort_sched.sv
// Directed bench for crc_sort_sched with a behavioural crc_sort_core stand-in.
module tb_crc_sort_sched;
  import crc_sort_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [3*NUM_REQ-1:0]   req_fn_sel = '0;
  logic [128*NUM_REQ-1:0] req_data = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [IDW-1:0]         rsp_id;
  logic [127:0]           rsp_data;
  logic                   rsp_err;
  logic                   busy;
  logic                   core_start;
  logic [2:0]             core_fn_sel;
  logic [127:0]           core_data_in;
  logic [127:0]           core_data_out;
  logic                   core_done;

  always #5 clk = ~clk;

  crc_sort_sched #(
    .NUM_REQ     (NUM_REQ),
    .IDW         (IDW),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_fn_sel    (req_fn_sel),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .core_start    (core_start),
    .core_fn_sel   (core_fn_sel),
    .core_data_in  (core_data_in),
    .core_data_out (core_data_out),
    .core_done     (core_done)
  );

  function automatic logic [127:0] sort_bytes(input logic [127:0] d);
    logic [7:0] b [16];
    logic [7:0] t;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = d[8*i +: 8];
    for (int i = 0; i < 15; i++)
      for (int j = 0; j < 15 - i; j++)
        if (b[j] > b[j+1]) begin t = b[j]; b[j] = b[j+1]; b[j+1] = t; end
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  // Core stand-in: done pulses so that rsp_valid rises LAT+1 cycles after core_start.
  int unsigned  cm_cnt;
  logic [2:0]   cm_fn;
  logic [127:0] cm_data;
  logic         kill_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_cnt        <= 0;
      cm_fn         <= '0;
      cm_data       <= '0;
      core_done     <= 1'b0;
      core_data_out <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        cm_cnt  <= ((core_fn_sel == FN_CRC_GEN) ? CRC_LAT : SORT_LAT) - 1;
        cm_fn   <= core_fn_sel;
        cm_data <= core_data_in;
      end else if (cm_cnt != 0) begin
        cm_cnt <= cm_cnt - 1;
        if (cm_cnt == 1 && !kill_done) begin
          core_done     <= 1'b1;
          core_data_out <= (cm_fn == FN_SORT) ? sort_bytes(cm_data)
                                              : {125'd0, cm_data[2:0] ^ cm_data[10:8]};
        end
      end
    end
  end

  int         cyc = 0;
  int         start_cnt = 0, start_cyc = 0, rise_cyc = 0, fn_changes = 0;
  logic       prev_rv = 1'b0;
  logic [2:0] fn_at_start = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (core_start) begin
      start_cnt   <= start_cnt + 1;
      start_cyc   <= cyc;
      fn_at_start <= core_fn_sel;
    end else if (busy && cm_cnt != 0 && core_fn_sel !== fn_at_start) begin
      fn_changes <= fn_changes + 1;
    end
    if (rsp_valid && !prev_rv) rise_cyc <= cyc;
    prev_rv <= rsp_valid;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2idx(input logic [NUM_REQ-1:0] oh);
    for (int i = 0; i < NUM_REQ; i++) if (oh[i]) return i;
    return -1;
  endfunction

  task automatic wait_grant(output int idx, output int waited);
    bit got = 0;
    idx = -1;
    waited = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      #1;
      if (req_ready != '0) begin
        got = 1;
        idx = oh2idx(req_ready);
        check("grant_onehot", $countones(req_ready), 1);
      end else begin
        tick();
        waited++;
      end
    end
    if (!got) check("grant_timeout", 1, 0);
  endtask

  task automatic get_rsp();
    bit got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      #1;
      if (rsp_valid) got = 1;
      else tick();
    end
    if (!got) check("rsp_timeout", 1, 0);
    @(negedge clk);
    #1;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  int g, w, s0;
  int exp_rr [4];

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_outputs", {req_ready, rsp_valid, rsp_id, rsp_err, busy, core_start, core_fn_sel, rsp_data}, '0);
    check("rst_core_data", core_data_in, '0);
    rst_n = 1'b1;
    tick();

    // T1: req0 SORT
    s0 = start_cnt;
    req_fn_sel[2:0] = FN_SORT;
    req_data[127:0] = 128'h000102030405060708090A0B0C0D0E0F;
    req_valid = 4'b0001;
    wait_grant(g, w);
    check("t1_grant", g, 0);
    tick();
    req_valid = '0;
    get_rsp();
    check("t1_data", rsp_data, 128'h0F0E0D0C0B0A09080706050403020100);
    check("t1_id_err", {rsp_id, rsp_err}, {2'd0, 1'b0});
    check("t1_starts", start_cnt - s0, 1);
    check("t1_latency", rise_cyc - start_cyc, 19);
    handshake();

    // T2: req2 CRC of zero
    s0 = start_cnt;
    req_fn_sel[8:6] = FN_CRC_GEN;
    req_data[383:256] = '0;
    req_valid = 4'b0100;
    wait_grant(g, w);
    check("t2_grant", g, 2);
    tick();
    req_valid = '0;
    get_rsp();
    check("t2_data", rsp_data, '0);
    check("t2_id_err", {rsp_id, rsp_err}, {2'd2, 1'b0});
    check("t2_starts", start_cnt - s0, 1);
    check("t2_latency", rise_cyc - start_cyc, 131);
    check("t2_fn_stable", fn_changes, 0);
    handshake();

    // T5: response back-pressure, with req1 waiting
    req_fn_sel[11:9] = FN_SORT;
    req_data[511:384] = 128'hFF000000000000000000000000000001;
    req_valid = 4'b1000;
    wait_grant(g, w);
    check("t5_grant", g, 3);
    tick();
    req_fn_sel[5:3] = 3'b111;
    req_valid = 4'b0010;
    get_rsp();
    for (int i = 0; i < 10; i++) begin
      check("t5_hold", {rsp_valid, rsp_id, rsp_err, rsp_data, req_ready, busy},
            {1'b1, 2'd3, 1'b0, 128'hFF010000000000000000000000000000, 4'b0000, 1'b1});
      tick();
    end
    handshake();

    // T4: illegal fn from req1 follows immediately
    s0 = start_cnt;
    wait_grant(g, w);
    check("t4_grant", g, 1);
    check("t5_next_grant_wait", w, 0);
    tick();
    req_valid = '0;
    check("t4_resp_next", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, 2'd1, 1'b1, 128'd0});
    @(negedge clk);
    #1;
    check("t4_no_start", start_cnt - s0, 0);
    handshake();

    // T6: reset in the middle of WAIT
    req_fn_sel[8:6] = FN_SORT;
    req_data[383:256] = 128'h0F0E0D0C0B0A09080706050403020100;
    req_valid = 4'b0100;
    wait_grant(g, w);
    check("t6_grant", g, 2);
    tick();
    req_valid = '0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_outputs", {req_ready, rsp_valid, rsp_id, rsp_err, busy, core_start, core_fn_sel, rsp_data}, '0);
    check("t6_rst_core_data", core_data_in, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    s0 = start_cnt;
    req_data[511:384] = 128'h00000000000000000000000000000201;
    req_valid = 4'b1000;
    wait_grant(g, w);
    check("t6_grant_after_rst", g, 3);
    tick();
    req_valid = '0;
    get_rsp();
    check("t6_data", rsp_data, 128'h02010000000000000000000000000000);
    check("t6_id_err", {rsp_id, rsp_err}, {2'd3, 1'b0});
    check("t6_starts", start_cnt - s0, 1);
    check("t6_latency", rise_cyc - start_cyc, 19);
    handshake();

    // T3: round-robin order, rr_ptr back at 0
    req_fn_sel = {FN_SORT, FN_SORT, FN_SORT, FN_SORT};
    req_data = '0;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, w);
      check("t3_rr_grant", g, k);
      tick();
      if (g >= 0) req_valid[g] = 1'b0;
      get_rsp();
      check("t3_rr_rsp", {rsp_id, rsp_err, rsp_data}, {2'(k), 1'b0, 128'd0});
      handshake();
    end
    req_fn_sel[2:0] = 3'b000;
    req_valid = 4'b1001;
    exp_rr = '{0, 3, 0, 3};
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, w);
      check("t3_alt_grant", g, exp_rr[k]);
      tick();
      get_rsp();
      check("t3_alt_rsp", {rsp_id, rsp_err}, {2'(exp_rr[k]), exp_rr[k] == 0});
      handshake();
    end
    req_valid = '0;

`ifdef CRC_SORT_SCHED_TIMEOUT_EN
    kill_done = 1'b1;
    req_fn_sel[2:0] = FN_CRC_GEN;
    req_valid = 4'b0001;
    wait_grant(g, w);
    check("wd_grant", g, 0);
    tick();
    req_valid = '0;
    get_rsp();
    check("wd_rsp", {rsp_id, rsp_err, rsp_data}, {2'd0, 1'b1, 128'd0});
    check("wd_latency", rise_cyc - start_cyc, 256);
    handshake();
    repeat (150) tick();
    kill_done = 1'b0;
`endif

    check("fn_stable_all", fn_changes, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
